seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 4096: clk cycles per digit slot; legal range 2..65536.
REQ-002 SHALL have parameter BLINK_FRAMES, default 64: scan frames per blink half-period; legal range 1..1024.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset; asynchronous and active-high.
REQ-005 SHALL have port en  in  1  scan enable.
REQ-006 SHALL have port wr_en  in  1  shadow-buffer write strobe.
REQ-007 SHALL have port wr_addr  in  2  digit index written.
REQ-008 SHALL have port wr_data  in  6  digit code: bits[3:0] value, bit5 decimal point, code 0 = blank.
REQ-009 SHALL have port commit  in  1  request to copy shadow into active at the next frame boundary.
REQ-010 SHALL have port blink_mask  in  4  per-digit blink enable, bit i = digit i.
REQ-011 SHALL have port showDigit  out  4  current digit index, binary 0..3 in bits[1:0]; bits[3:2] always 0.
REQ-012 SHALL have port showNum  out  6  code for the current digit, feeding the display driver.
REQ-013 SHALL have port scan_tick  out  1  one-cycle pulse, coincident with each new showDigit/showNum.
REQ-014 SHALL have port busy  out  1  commit pending.
REQ-015 SHALL have port frame_done  out  1  one-cycle pulse at each frame boundary.

Function
REQ-016 SHALL keep a prescaler cnt counting 0..DIV-1 while en=1; slot end = (cnt==DIV-1 && en); cnt wraps to 0 at slot end.
REQ-017 SHALL keep a 2-bit idx; at slot end idx <= idx+1 mod 4. On the same edge: showDigit <= new idx, showNum <= disp(new idx), scan_tick <= 1. scan_tick SHALL be 0 in all other cycles.
REQ-018 SHALL define disp(i) = 6'd0 when blink_mask[i]=1 and phase=1; otherwise active[i].
REQ-019 SHALL hold four 6-bit shadow entries; wr_en=1 writes wr_data to shadow[wr_addr] on that edge. Writes SHALL be accepted regardless of en, busy or commit.
REQ-020 SHALL define a frame boundary as a slot end where idx changes from 3 to 0; frame_done SHALL pulse for one cycle on that edge.
REQ-021 SHALL set busy <= 1 on the edge after commit=1 is sampled with busy=0. commit while busy=1 SHALL be ignored, with no queueing.
REQ-022 SHALL, at a frame boundary with busy=1, copy all four shadow entries to active and clear busy. showNum for digit 0 on that edge SHALL use the newly copied value.
REQ-023 SHALL NOT transfer at a boundary coinciding with the commit that sets busy; that transfer occurs at the following boundary.
REQ-024 SHALL, when wr_en coincides with a transfer, copy the pre-write shadow contents; the write lands in shadow only.
REQ-025 SHALL keep a frame counter 0..BLINK_FRAMES-1, advanced at each frame boundary. On wrap to 0, phase SHALL toggle.
REQ-026 SHALL, while en=0: hold cnt, idx, frame counter, phase and showDigit; drive showNum <= 0 on each edge; drive scan_tick=0 and frame_done=0. A pending busy SHALL remain set.
REQ-027 SHALL, when en returns to 1, resume counting from the held cnt. showNum stays 0 until the next slot end.
REQ-028 SHALL size cnt as clog2(DIV) bits and the frame counter as clog2(BLINK_FRAMES) bits, minimum 1. All counter arithmetic SHALL wrap modulo its terminal value, never modulo 2^width.

Reset
REQ-029 SHALL, while rst=1 (asynchronously), force: cnt=0, idx=0, showDigit=0, showNum=0, all shadow and active entries 0, busy=0, scan_tick=0, frame_done=0, phase=0, frame counter=0.
REQ-030 SHALL, on reset asserted mid-frame or with busy=1, discard the pending commit and all buffer contents. The first slot end after release SHALL occur DIV cycles after the first en=1 edge and SHALL show digit 1.

Verification (DIV=4, BLINK_FRAMES=2)
REQ-031 Bench SHALL check scan order: write codes 1,2,3,4 to digits 0..3, commit, en=1 -> at slot ends showDigit goes 1,2,3,0,1...; showNum is 0 until the first boundary, then 1 on digit 0, 2 on digit 1, and so on; scan_tick period is 4 cycles.
REQ-032 Bench SHALL check commit handshake: commit at cycle 0 -> busy=1 from cycle 1; a second commit while busy has no effect; busy=0 on the boundary edge where frame_done=1.
REQ-033 Bench SHALL check write/transfer collision: shadow[0]=5; write 9 to digit 0 on the transfer edge -> active[0]=5 is displayed; after the next commit and boundary, digit 0 shows 9.
REQ-034 Bench SHALL check blinking: blink_mask=4'b0100 with digit 2 code 7 -> digit 2 shows 7 for 2 frames, 0 for 2 frames, repeating; the other digits are unaffected.
REQ-035 Bench SHALL check enable gating: en=0 mid-slot for 10 cycles -> showNum=0 and no scan_tick; idx held; after en=1, the next slot end comes after the remaining cnt cycles.
REQ-036 Bench SHALL check asynchronous reset: rst pulse between clock edges with busy=1 -> all outputs 0 immediately; busy=0; the display stays blank after re-enable until a new write and commit.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: four-digit multiplexed display scanner.
// Double-buffered digit codes, frame-aligned commit, per-digit blink.
module seg_scan_ctrl #(
  parameter int DIV          = 4096,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [5:0] wr_data,
  input  logic       commit,
  input  logic [3:0] blink_mask,
  output logic [3:0] showDigit,
  output logic [5:0] showNum,
  output logic       scan_tick,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);
  localparam logic [FW-1:0] FRM_ONE = FW'(1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [FW-1:0] fcnt;
  logic          phase;

  logic [5:0] shadow [4];
  logic [5:0] active [4];

  logic       slot_end;
  logic       boundary;
  logic       xfer;
  logic [1:0] nidx;
  logic [5:0] nxt_code;

  always_comb begin
    nidx     = idx + 2'd1;
    slot_end = en && (cnt == CNT_MAX);
    boundary = slot_end && (idx == 2'd3);
    xfer     = boundary && busy;
    // digit 0 on a transfer edge must show the freshly copied code
    nxt_code = xfer ? shadow[nidx] : active[nidx];
    if (blink_mask[nidx] && phase) begin
      nxt_code = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= nidx;
      if (boundary) begin
        if (fcnt == FRM_MAX) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + FRM_ONE;
        end
      end
    end else if (en) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        shadow[wr_addr] <= wr_data;
      end
      if (xfer) begin
        busy <= 1'b0;
        for (int i = 0; i < 4; i++) begin
          active[i] <= shadow[i];
        end
      end else if (commit && !busy) begin
        busy <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      showDigit  <= '0;
      showNum    <= '0;
      scan_tick  <= 1'b0;
      frame_done <= 1'b0;
    end else if (!en) begin
      showNum    <= '0;
      scan_tick  <= 1'b0;
      frame_done <= 1'b0;
    end else if (slot_end) begin
      showDigit  <= {2'b00, nidx};
      showNum    <= nxt_code;
      scan_tick  <= 1'b1;
      frame_done <= boundary;
    end else begin
      scan_tick  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule
